ritc_dac_chain_rx: RTL and testbench



---
 rtl/ritc_dac_chain_rx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ritc_dac_chain_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_dac_chain_rx.sv
// ritc_dac_chain_rx: receive end of the RITC DAC serial load protocol.
// Deserializes DIN/CLOCK (MSB first, inverted bits) into NUM_DACS words of
// DAC_BITS each, and commits a complete frame to a ping-pong register file on
// a LATCH rising edge.
// Optional macro RITC_DAC_CHAIN_RX_SYNC_EN: adds a 2-flop synchronizer in
// front of the input register so the serial pins may come from another clock
// domain (input-to-shift latency 3 instead of 1 clk_i cycles).
module ritc_dac_chain_rx #(
    parameter int NUM_DACS  = 33,
    parameter int DAC_BITS  = 12,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dac_din_i,
    input  logic                 dac_clock_i,
    input  logic                 dac_latch_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [DAC_BITS-1:0]  rd_dat_o,
    output logic                 valid_o,
    output logic                 update_o,
    output logic                 frame_err_o,
    input  logic                 err_clr_i,
    output logic                 busy_o,
    output logic [ADDR_BITS-1:0] word_cnt_o,
    output logic [7:0]           latch_cnt_o
);

    localparam int BC_W = $clog2(DAC_BITS + 1);
    localparam logic [BC_W-1:0]      BIT_LAST  = BC_W'(DAC_BITS - 1);
    localparam logic [ADDR_BITS-1:0] WORDS_MAX = ADDR_BITS'(NUM_DACS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input stage: {din, clock, latch}
    // ------------------------------------------------------------------
    logic [2:0] pin_s;
    logic [2:0] in_r;
    logic [1:0] prev_r;

`ifdef RITC_DAC_CHAIN_RX_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic [2:0] meta_r;
    (* ASYNC_REG = "TRUE" *) logic [2:0] sync_r;

    // Two-flop synchronizer for pins driven from a foreign clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_r <= 3'b000;
            sync_r <= 3'b000;
        end else begin
            meta_r <= {dac_din_i, dac_clock_i, dac_latch_i};
            sync_r <= meta_r;
        end
    end

    assign pin_s = sync_r;
`else
    assign pin_s = {dac_din_i, dac_clock_i, dac_latch_i};
`endif

    // Input register plus previous-value register for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_r   <= 3'b000;
            prev_r <= 2'b00;
        end else begin
            in_r   <= pin_s;
            prev_r <= in_r[1:0];
        end
    end

    logic din_s;
    logic clk_rise_s;
    logic latch_rise_s;

    assign din_s        = in_r[2];
    assign clk_rise_s   = in_r[1] & ~prev_r[1];
    assign latch_rise_s = in_r[0] & ~prev_r[0];

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t state_r;
    state_t state_next_s;
    logic   shift_en_s;
    logic   check_s;
    logic   idle_err_s;

    // Next-state decode; LATCH beats CLOCK when both rise together.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        check_s      = 1'b0;
        idle_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (latch_rise_s) begin
                    idle_err_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (clk_rise_s) begin
                    shift_en_s   = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (latch_rise_s) begin
                    state_next_s = ST_CHECK;
                end else if (clk_rise_s) begin
                    shift_en_s   = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                check_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Deserializer datapath
    // ------------------------------------------------------------------
    logic [DAC_BITS-2:0]  shift_r;
    logic [BC_W-1:0]      bit_cnt_r;
    logic [ADDR_BITS-1:0] word_cnt_r;
    logic                 ovf_r;

    logic [DAC_BITS-1:0]  word_s;
    logic                 word_done_s;
    logic                 wr_en_s;
    logic                 ovf_s;
    logic                 good_s;
    logic                 err_set_s;

    // Word assembly, overflow detection and frame check decode.
    always_comb begin
        word_s      = {shift_r, ~din_s};
        word_done_s = shift_en_s && (bit_cnt_r == BIT_LAST);
        wr_en_s     = word_done_s && (word_cnt_r < WORDS_MAX);
        ovf_s       = word_done_s && (word_cnt_r >= WORDS_MAX);
        good_s      = check_s && (word_cnt_r == WORDS_MAX) &&
                      (bit_cnt_r == {BC_W{1'b0}}) && !ovf_r;
        err_set_s   = idle_err_s || ovf_s || (check_s && !good_s);
    end

    // Bit/word counters and shift register; cleared when a frame is checked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            word_cnt_r <= '0;
            ovf_r      <= 1'b0;
        end else if (check_s) begin
            bit_cnt_r  <= '0;
            word_cnt_r <= '0;
            ovf_r      <= 1'b0;
        end else if (shift_en_s) begin
            shift_r <= word_s[DAC_BITS-2:0];
            if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r <= '0;
                if (wr_en_s) begin
                    word_cnt_r <= word_cnt_r + 1'b1;
                end else begin
                    ovf_r <= 1'b1;
                end
            end else begin
                bit_cnt_r <= bit_cnt_r + 1'b1;
            end
        end else begin
            shift_r <= shift_r;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong register file (contents deliberately not reset)
    // ------------------------------------------------------------------
    logic [DAC_BITS-1:0] bank_mem [0:1][0:NUM_DACS-1];
    logic                bank_sel_r;

    // Completed words land in the shadow bank (the one not selected).
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            bank_mem[~bank_sel_r][word_cnt_r] <= word_s;
        end
    end

    // ------------------------------------------------------------------
    // Status / commit registers
    // ------------------------------------------------------------------
    logic       update_r;
    logic       valid_r;
    logic       frame_err_r;
    logic       busy_r;
    logic [7:0] latch_cnt_r;

    // State register, bank swap on commit, sticky error with set priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            bank_sel_r  <= 1'b0;
            update_r    <= 1'b0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            latch_cnt_r <= 8'd0;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= (state_next_s != ST_IDLE);
            update_r <= good_s;
            if (good_s) begin
                bank_sel_r  <= ~bank_sel_r;
                valid_r     <= 1'b1;
                latch_cnt_r <= latch_cnt_r + 8'd1;
            end else begin
                bank_sel_r  <= bank_sel_r;
            end
            if (err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic [DAC_BITS-1:0] rd_word_s;
    logic [DAC_BITS-1:0] rd_dat_r;

    // Active-bank lookup; addresses past the last DAC read as zero.
    always_comb begin
        rd_word_s = '0;
        if (rd_addr_i < WORDS_MAX) begin
            rd_word_s = bank_mem[bank_sel_r][rd_addr_i];
        end else begin
            rd_word_s = '0;
        end
    end

    // Registered read data, one cycle after the address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_dat_r <= '0;
        end else begin
            rd_dat_r <= rd_word_s;
        end
    end

    assign rd_dat_o    = rd_dat_r;
    assign valid_o     = valid_r;
    assign update_o    = update_r;
    assign frame_err_o = frame_err_r;
    assign busy_o      = busy_r;
    assign word_cnt_o  = word_cnt_r;
    assign latch_cnt_o = latch_cnt_r;

endmodule

// File: tb/tb_ritc_dac_chain_rx.sv
// Directed self-checking bench for ritc_dac_chain_rx.
module tb_ritc_dac_chain_rx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dac_din_i = 1'b0;
    logic        dac_clock_i = 1'b0;
    logic        dac_latch_i = 1'b0;
    logic [5:0]  rd_addr_i = 6'd0;
    logic [11:0] rd_dat_o;
    logic        valid_o;
    logic        update_o;
    logic        frame_err_o;
    logic        err_clr_i = 1'b0;
    logic        busy_o;
    logic [5:0]  word_cnt_o;
    logic [7:0]  latch_cnt_o;

    int errors = 0;
    int checks = 0;
    int n_upd  = 0;

    ritc_dac_chain_rx dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dac_din_i   (dac_din_i),
        .dac_clock_i (dac_clock_i),
        .dac_latch_i (dac_latch_i),
        .rd_addr_i   (rd_addr_i),
        .rd_dat_o    (rd_dat_o),
        .valid_o     (valid_o),
        .update_o    (update_o),
        .frame_err_o (frame_err_o),
        .err_clr_i   (err_clr_i),
        .busy_o      (busy_o),
        .word_cnt_o  (word_cnt_o),
        .latch_cnt_o (latch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One loader bit: data inverted, CLOCK low one cycle then high one cycle.
    task automatic send_bit(input logic b);
        dac_din_i   = ~b;
        dac_clock_i = 1'b0;
        tick();
        dac_clock_i = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [11:0] v);
        for (int i = 11; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_ramp(input int nwords);
        logic [11:0] v;
        for (int k = 0; k < nwords; k++) begin
            v = 12'(100 * k + 5);
            send_word(v);
        end
    endtask

    task automatic send_const(input int nwords, input logic [11:0] v);
        for (int k = 0; k < nwords; k++) send_word(v);
    endtask

    // LATCH pulse, then watch a bounded window counting update_o pulses.
    task automatic do_latch();
        dac_clock_i = 1'b0;
        tick();
        tick();
        dac_latch_i = 1'b1;
        n_upd = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) dac_latch_i = 1'b0;
            tick();
            n_upd += int'(update_o);
        end
    endtask

    task automatic rd_check(input string tag, input logic [5:0] a, input logic [11:0] exp);
        rd_addr_i = a;
        tick();
        check(tag, {20'd0, rd_dat_o}, {20'd0, exp});
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        dac_clock_i = 1'b0;
        dac_latch_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_rd_dat", {20'd0, rd_dat_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_update", {31'd0, update_o}, 32'd0);
        check("rst_err", {31'd0, frame_err_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_word_cnt", {26'd0, word_cnt_o}, 32'd0);
        check("rst_latch_cnt", {24'd0, latch_cnt_o}, 32'd0);

        // Good frame v[k] = 100k+5
        send_ramp(33);
        dac_clock_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("good_word_cnt", {26'd0, word_cnt_o}, 32'd33);
        check("good_busy", {31'd0, busy_o}, 32'd1);
        do_latch();
        check("good_updates", n_upd, 32'd1);
        check("good_valid", {31'd0, valid_o}, 32'd1);
        check("good_latch_cnt", {24'd0, latch_cnt_o}, 32'd1);
        check("good_err", {31'd0, frame_err_o}, 32'd0);
        check("good_busy_end", {31'd0, busy_o}, 32'd0);
        check("good_word_cnt_end", {26'd0, word_cnt_o}, 32'd0);
        rd_check("good_rd0", 6'd0, 12'd5);
        rd_check("good_rd17", 6'd17, 12'd1705);
        rd_check("good_rd32", 6'd32, 12'd3205);
        rd_check("good_rd40", 6'd40, 12'd0);

        // Short frame: 32 words
        send_const(32, 12'hFFF);
        do_latch();
        check("short_err", {31'd0, frame_err_o}, 32'd1);
        check("short_updates", n_upd, 32'd0);
        check("short_latch_cnt", {24'd0, latch_cnt_o}, 32'd1);
        rd_check("short_rd0", 6'd0, 12'd5);
        rd_check("short_rd32", 6'd32, 12'd3205);
        clear_err();
        check("short_err_clr", {31'd0, frame_err_o}, 32'd0);

        // Partial word: 33 words + 5 bits
        send_const(33, 12'h555);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_latch();
        check("partial_err", {31'd0, frame_err_o}, 32'd1);
        check("partial_updates", n_upd, 32'd0);
        check("partial_latch_cnt", {24'd0, latch_cnt_o}, 32'd1);
        rd_check("partial_rd5", 6'd5, 12'd505);
        clear_err();
        check("partial_err_clr", {31'd0, frame_err_o}, 32'd0);

        // Overflow: 34 words
        send_const(34, 12'h0F0);
        do_latch();
        check("ovf_err", {31'd0, frame_err_o}, 32'd1);
        check("ovf_updates", n_upd, 32'd0);
        check("ovf_latch_cnt", {24'd0, latch_cnt_o}, 32'd1);
        rd_check("ovf_rd1", 6'd1, 12'd105);
        clear_err();

        // LATCH with no bits received
        do_latch();
        check("idle_latch_err", {31'd0, frame_err_o}, 32'd1);
        check("idle_latch_updates", n_upd, 32'd0);
        clear_err();

        // Back-to-back frames from a fresh reset
        do_reset();
        send_const(33, 12'hABC);
        do_latch();
        check("ab_a_updates", n_upd, 32'd1);
        check("ab_a_latch_cnt", {24'd0, latch_cnt_o}, 32'd1);
        rd_check("ab_a_rd0", 6'd0, 12'hABC);
        rd_check("ab_a_rd32", 6'd32, 12'hABC);
        send_const(33, 12'h123);
        do_latch();
        check("ab_b_updates", n_upd, 32'd1);
        check("ab_b_latch_cnt", {24'd0, latch_cnt_o}, 32'd2);
        rd_check("ab_b_rd0", 6'd0, 12'h123);
        rd_check("ab_b_rd32", 6'd32, 12'h123);
        check("ab_err", {31'd0, frame_err_o}, 32'd0);

        // LATCH rising together with the final CLOCK edge
        send_const(32, 12'h777);
        for (int i = 11; i >= 1; i--) send_bit(1'b0);
        dac_din_i   = 1'b1;
        dac_clock_i = 1'b0;
        tick();
        tick();
        dac_clock_i = 1'b1;
        dac_latch_i = 1'b1;
        tick();
        tick();
        dac_latch_i = 1'b0;
        dac_clock_i = 1'b0;
        n_upd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_upd += int'(update_o);
        end
        check("simul_err", {31'd0, frame_err_o}, 32'd1);
        check("simul_updates", n_upd, 32'd0);
        check("simul_latch_cnt", {24'd0, latch_cnt_o}, 32'd2);
        check("simul_busy", {31'd0, busy_o}, 32'd0);
        rd_check("simul_rd3", 6'd3, 12'h123);

        // Reset mid-frame, then a clean frame
        send_const(10, 12'h9A5);
        rst_i       = 1'b1;
        dac_clock_i = 1'b0;
        tick();
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_err", {31'd0, frame_err_o}, 32'd0);
        check("midrst_word_cnt", {26'd0, word_cnt_o}, 32'd0);
        check("midrst_latch_cnt", {24'd0, latch_cnt_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        send_ramp(33);
        do_latch();
        check("postrst_updates", n_upd, 32'd1);
        check("postrst_latch_cnt", {24'd0, latch_cnt_o}, 32'd1);
        check("postrst_valid", {31'd0, valid_o}, 32'd1);
        check("postrst_err", {31'd0, frame_err_o}, 32'd0);
        rd_check("postrst_rd0", 6'd0, 12'd5);
        rd_check("postrst_rd32", 6'd32, 12'd3205);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
